// File: rtl/gpio_in_stage.sv
// rtl/gpio_in_stage.sv - GPIO input synchronizer, sampler and sticky interrupt status
// Define GPIO_ECLK_SAMPLE_EN to build per-bit sampling on the gpio_eclk active edge.
module gpio_in_stage (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] in_pad_i,
  input  logic        gpio_eclk,
  input  logic        nec,
  input  logic [31:0] eclk_sel,
  input  logic [31:0] ptrig,
  input  logic [31:0] inte,
  input  logic        ctrl_inte,
  input  logic [31:0] ints_clr,
  output logic [31:0] in_sync_o,
  output logic [31:0] ints_o,
  output logic        irq_o
);

  logic [31:0] pad_s1;
  logic [31:0] pad_s2;
  logic [31:0] prev;
  logic [31:0] sample_en;
  logic [31:0] evt;

  // Two-flop pad synchronizer; s1 feeds s2 with nothing in between
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pad_s1 <= '0;
      pad_s2 <= '0;
    end else begin
      pad_s1 <= in_pad_i;
      pad_s2 <= pad_s1;
    end
  end

`ifdef GPIO_ECLK_SAMPLE_EN
  logic eclk_s1;
  logic eclk_s2;
  logic eclk_d;
  logic eclk_edge;

  // gpio_eclk is only data here: synchronize it and keep one cycle of history
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      eclk_s1 <= 1'b0;
      eclk_s2 <= 1'b0;
      eclk_d  <= 1'b0;
    end else begin
      eclk_s1 <= gpio_eclk;
      eclk_s2 <= eclk_s1;
      eclk_d  <= eclk_s2;
    end
  end

  // One-pclk pulse on the selected active edge of the synchronized eclk
  always_comb begin
    eclk_edge = 1'b0;
    if (nec) begin
      eclk_edge = ~eclk_s2 & eclk_d;
    end else begin
      eclk_edge = eclk_s2 & ~eclk_d;
    end
  end

  assign sample_en = ~eclk_sel | {32{eclk_edge}};
`else
  logic unused_eclk;

  assign unused_eclk = ^{gpio_eclk, nec, eclk_sel};
  assign sample_en   = '1;
`endif

  // Sampled readback: load enabled bits from s2, hold the others
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      in_sync_o <= '0;
    end else begin
      in_sync_o <= (pad_s2 & sample_en) | (in_sync_o & ~sample_en);
    end
  end

  // Previous readback value for edge detection
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prev <= '0;
    end else begin
      prev <= in_sync_o;
    end
  end

  // Per-bit edge event on the edge direction chosen by ptrig
  always_comb begin
    evt = '0;
    evt = (ptrig & in_sync_o & ~prev) | (~ptrig & ~in_sync_o & prev);
  end

  // Sticky status: enabled events set, write-1 clears, set wins on collision
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ints_o <= '0;
    end else begin
      ints_o <= (ints_o & ~ints_clr) | (evt & inte);
    end
  end

  // Registered interrupt request gated by the global enable
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= ctrl_inte & (|ints_o);
    end
  end

endmodule

// File: tb/tb_gpio_in_stage.sv
// tb/tb_gpio_in_stage.sv - self-checking bench for gpio_in_stage
module tb_gpio_in_stage;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] in_pad_i;
  logic        gpio_eclk;
  logic        nec;
  logic [31:0] eclk_sel;
  logic [31:0] ptrig;
  logic [31:0] inte;
  logic        ctrl_inte;
  logic [31:0] ints_clr;
  logic [31:0] in_sync_o;
  logic [31:0] ints_o;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  // Reference model: readback is the pad value from 3 cycles earlier,
  // status follows the set/clear rules on readback changes
  logic [31:0] pad_q[$];
  logic [31:0] m_sync;
  logic [31:0] m_sync_old;
  logic [31:0] m_ints;
  logic        m_irq;

  gpio_in_stage dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .in_pad_i  (in_pad_i),
    .gpio_eclk (gpio_eclk),
    .nec       (nec),
    .eclk_sel  (eclk_sel),
    .ptrig     (ptrig),
    .inte      (inte),
    .ctrl_inte (ctrl_inte),
    .ints_clr  (ints_clr),
    .in_sync_o (in_sync_o),
    .ints_o    (ints_o),
    .irq_o     (irq_o)
  );

  always #5 pclk = ~pclk;

  task automatic model_reset();
    pad_q      = {32'h0, 32'h0};
    m_sync     = '0;
    m_sync_old = '0;
    m_ints     = '0;
    m_irq      = 1'b0;
  endtask

  // Advance one pclk; model updates at the edge, returns at the falling edge
  task automatic tick();
    logic [31:0] rose;
    logic [31:0] fell;
    @(posedge pclk);
    if (!presetn) begin
      model_reset();
    end else begin
      rose       = m_sync & ~m_sync_old;
      fell       = m_sync_old & ~m_sync;
      m_irq      = ctrl_inte && (m_ints != 32'h0);
      m_ints     = (m_ints & ~ints_clr) | (((rose & ptrig) | (fell & ~ptrig)) & inte);
      m_sync_old = m_sync;
      m_sync     = pad_q.pop_front();
      pad_q.push_back(in_pad_i);
    end
    @(negedge pclk);
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) tick();
    total++; if (in_sync_o !== 32'h0) begin bad++; $display("FAIL reset_in_sync got=%h exp=%h", in_sync_o, 32'h0); end
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL reset_ints got=%h exp=%h", ints_o, 32'h0); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_readback();
    in_pad_i = 32'h0;
    repeat (4) tick();
    in_pad_i = 32'h0000_00A5;
    repeat (2) tick();
    total++; if (in_sync_o !== 32'h0) begin bad++; $display("FAIL readback_early got=%h exp=%h", in_sync_o, 32'h0); end
    tick();
    total++; if (in_sync_o !== 32'h0000_00A5) begin bad++; $display("FAIL readback_3clk got=%h exp=%h", in_sync_o, 32'h0000_00A5); end
    total++; if (in_sync_o !== m_sync) begin bad++; $display("FAIL readback_model got=%h exp=%h", in_sync_o, m_sync); end
  endtask

  task automatic test_rise_irq();
    ptrig     = 32'h8;
    inte      = 32'h8;
    ctrl_inte = 1'b1;
    in_pad_i  = 32'h0000_00AD;
    repeat (3) tick();
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL rise_early got=%h exp=%h", ints_o, 32'h0); end
    tick();
    total++; if (ints_o !== 32'h8) begin bad++; $display("FAIL rise_set got=%h exp=%h", ints_o, 32'h8); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL rise_irq_early got=%b exp=0", irq_o); end
    tick();
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL rise_irq got=%b exp=1", irq_o); end
    ints_clr = 32'h8;
    tick();
    ints_clr = 32'h0;
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL rise_clr got=%h exp=%h", ints_o, 32'h0); end
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL rise_irq_hold got=%b exp=1", irq_o); end
    tick();
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL rise_irq_drop got=%b exp=0", irq_o); end
  endtask

  task automatic test_fall_mask();
    in_pad_i = 32'h0000_002D;
    repeat (6) tick();
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL fall_masked got=%h exp=%h", ints_o, 32'h0); end
    inte = 32'h88;
    repeat (4) tick();
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL fall_not_pended got=%h exp=%h", ints_o, 32'h0); end
  endtask

  task automatic test_set_clr();
    ptrig    = 32'h1;
    inte     = 32'h1;
    in_pad_i = 32'h0000_002C;
    repeat (5) tick();
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL setclr_pre got=%h exp=%h", ints_o, 32'h0); end
    in_pad_i = 32'h0000_002D;
    repeat (3) tick();
    ints_clr = 32'h1;
    tick();
    ints_clr = 32'h0;
    total++; if (ints_o[0] !== 1'b1) begin bad++; $display("FAIL setclr_set_wins got=%b exp=1", ints_o[0]); end
    total++; if (ints_o !== m_ints) begin bad++; $display("FAIL setclr_model got=%h exp=%h", ints_o, m_ints); end
    ints_clr = 32'h1;
    tick();
    ints_clr = 32'h0;
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL setclr_clear got=%h exp=%h", ints_o, 32'h0); end
  endtask

  task automatic test_static_cfg();
    inte = '1;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      ptrig    = $urandom;
      eclk_sel = $urandom;
      inte     = $urandom | 32'h0000_00FF;
      tick();
      total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL static_cfg cycle=%0d got=%h exp=%h", i, ints_o, 32'h0); end
    end
    eclk_sel = '0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_pad_i  = $urandom;
      if ($urandom_range(0, 7) == 0) ptrig = $urandom;
      if ($urandom_range(0, 7) == 0) inte = $urandom;
      ctrl_inte = $urandom_range(0, 3) != 0;
      ints_clr  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : 32'h0;
      tick();
      total++; if (in_sync_o !== m_sync) begin bad++; $display("FAIL rand_sync cycle=%0d got=%h exp=%h", i, in_sync_o, m_sync); end
      total++; if (ints_o !== m_ints) begin bad++; $display("FAIL rand_ints cycle=%0d got=%h exp=%h", i, ints_o, m_ints); end
      total++; if (irq_o !== m_irq) begin bad++; $display("FAIL rand_irq cycle=%0d got=%b exp=%b", i, irq_o, m_irq); end
    end
    ints_clr = 32'h0;
  endtask

`ifdef GPIO_ECLK_SAMPLE_EN
  task automatic test_eclk();
    inte      = '0;
    eclk_sel  = '0;
    gpio_eclk = 1'b1;
    nec       = 1'b1;
    in_pad_i  = 32'h0;
    repeat (5) tick();
    eclk_sel  = 32'h20;
    in_pad_i  = 32'h20;
    repeat (6) tick();
    total++; if (in_sync_o[5] !== 1'b0) begin bad++; $display("FAIL eclk_idle got=%b exp=0", in_sync_o[5]); end
    gpio_eclk = 1'b0;
    repeat (4) tick();
    total++; if (in_sync_o[5] !== 1'b1) begin bad++; $display("FAIL eclk_fall_sample got=%b exp=1", in_sync_o[5]); end
    in_pad_i = 32'h0;
    repeat (6) tick();
    total++; if (in_sync_o[5] !== 1'b1) begin bad++; $display("FAIL eclk_hold got=%b exp=1", in_sync_o[5]); end
    eclk_sel = '0;
    repeat (4) tick();
    total++; if (in_sync_o !== m_sync) begin bad++; $display("FAIL eclk_resync got=%h exp=%h", in_sync_o, m_sync); end
  endtask
`else
  task automatic test_eclk();
    logic [31:0] old_pad;
    inte     = '0;
    eclk_sel = '1;
    nec      = $urandom_range(0, 1);
    repeat (4) begin gpio_eclk = ~gpio_eclk; tick(); end
    old_pad  = in_pad_i;
    in_pad_i = ~old_pad;
    repeat (2) begin gpio_eclk = ~gpio_eclk; tick(); end
    total++; if (in_sync_o !== old_pad) begin bad++; $display("FAIL eclk_ignored_early got=%h exp=%h", in_sync_o, old_pad); end
    tick();
    total++; if (in_sync_o !== ~old_pad) begin bad++; $display("FAIL eclk_ignored_3clk got=%h exp=%h", in_sync_o, ~old_pad); end
    eclk_sel = '0;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    ptrig     = '1;
    inte      = '1;
    ctrl_inte = 1'b1;
    ints_clr  = '0;
    in_pad_i  = '0;
    repeat (5) tick();
    in_pad_i = '1;
    repeat (4) tick();
    total++; if (ints_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL midrst_pre got=%h exp=%h", ints_o, 32'hFFFF_FFFF); end
    #2;
    presetn  = 1'b0;
    in_pad_i = '0;
    #1;
    model_reset();
    total++; if (in_sync_o !== 32'h0) begin bad++; $display("FAIL midrst_sync got=%h exp=%h", in_sync_o, 32'h0); end
    total++; if (ints_o !== 32'h0) begin bad++; $display("FAIL midrst_ints got=%h exp=%h", ints_o, 32'h0); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", irq_o); end
    #1;
    presetn = 1'b1;
    @(negedge pclk);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (ints_o !== 32'h0 || irq_o !== 1'b0) begin bad++; $display("FAIL midrst_spurious cycle=%0d ints=%h irq=%b exp=0", i, ints_o, irq_o); end
    end
  endtask

  task automatic test_reset_pad_high();
    presetn  = 1'b0;
    in_pad_i = 32'h10;
    ptrig    = 32'h10;
    inte     = 32'h10;
    tick();
    presetn = 1'b1;
    repeat (2) tick();
    total++; if (in_sync_o !== 32'h0) begin bad++; $display("FAIL padhigh_early got=%h exp=%h", in_sync_o, 32'h0); end
    tick();
    total++; if (in_sync_o !== 32'h10) begin bad++; $display("FAIL padhigh_sync got=%h exp=%h", in_sync_o, 32'h10); end
    tick();
    total++; if (ints_o !== 32'h10) begin bad++; $display("FAIL padhigh_event got=%h exp=%h", ints_o, 32'h10); end
    tick();
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL padhigh_irq got=%b exp=1", irq_o); end
  endtask

  initial begin
    presetn   = 1'b0;
    in_pad_i  = '0;
    gpio_eclk = 1'b0;
    nec       = 1'b0;
    eclk_sel  = '0;
    ptrig     = '0;
    inte      = '0;
    ctrl_inte = 1'b0;
    ints_clr  = '0;
    model_reset();
    test_reset();
    test_readback();
    test_rise_irq();
    test_fall_mask();
    test_set_clr();
    test_static_cfg();
    test_random();
    test_eclk();
    test_reset_mid();
    test_reset_pad_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
